// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer with prescaler, compare/PWM output and a combined irq.
// Channel 0 sits at offsets 0-5 exactly like the single-channel interval timer it replaces.
module nios_multi_timer #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] timer_out
);

  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(DEFAULT_PERIOD);

  logic [15:0]       ch_rdata [4];
  logic [NUM_CH-1:0] ch_irq;
  logic [15:0]       readdata_reg;
  logic              wr_en;

  assign wr_en = chipselect & ~write_n;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg, period_reg, cmp_reg, snap_reg;
    logic [7:0]       presc_reg, presc_cnt_reg;
    logic             ito_reg, cont_reg, pwm_reg, run_reg, to_reg;
    logic             to_evt_reg, reload_pend_reg;
    logic             ch_wr, tick, wr_period;
    logic [7:0]       wr_off;
    logic [31:0]      period_ext, cmp_ext, snap_ext;
    logic [15:0]      rd_word;

    assign ch_wr      = wr_en & (address[4:3] == 2'(gi));
    assign wr_off     = ch_wr ? (8'd1 << address[2:0]) : 8'd0;
    assign wr_period  = wr_off[2] | wr_off[3];
    assign tick       = run_reg & (presc_cnt_reg == 8'd0);
    assign period_ext = 32'(period_reg);
    assign cmp_ext    = 32'(cmp_reg);
    assign snap_ext   = 32'(snap_reg);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg         <= PERIOD_INIT;
        period_reg      <= PERIOD_INIT;
        cmp_reg         <= '0;
        snap_reg        <= '0;
        presc_reg       <= '0;
        presc_cnt_reg   <= '0;
        ito_reg         <= 1'b0;
        cont_reg        <= 1'b0;
        pwm_reg         <= 1'b0;
        run_reg         <= 1'b0;
        to_reg          <= 1'b0;
        to_evt_reg      <= 1'b0;
        reload_pend_reg <= 1'b0;
      end else begin
        to_evt_reg <= 1'b0;
        if (tick) begin
          if (cnt_reg == '0) begin
            cnt_reg    <= period_reg;
            to_evt_reg <= 1'b1;
            if (!cont_reg) run_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        // A period write reloads the counter one cycle later, from the updated register.
        if (reload_pend_reg) cnt_reg <= period_reg;
        reload_pend_reg <= wr_period;

        if (!run_reg || tick) presc_cnt_reg <= presc_reg;
        else                  presc_cnt_reg <= presc_cnt_reg - 8'd1;

        if (wr_off[2]) period_reg[15:0]      <= writedata;
        if (wr_off[3]) period_reg[CNT_W-1:16] <= writedata[CNT_W-17:0];
        if (wr_period) run_reg <= 1'b0;
        if (wr_off[6]) cmp_reg[15:0]         <= writedata;
        if (wr_off[7]) cmp_reg[CNT_W-1:16]    <= writedata[CNT_W-17:0];
        if (wr_off[4] | wr_off[5]) snap_reg  <= cnt_reg;

        if (wr_off[1]) begin
          ito_reg   <= writedata[0];
          cont_reg  <= writedata[1];
          pwm_reg   <= writedata[4];
          presc_reg <= writedata[15:8];
          // START beats STOP, and restarts the prescaler without touching the counter.
          if (writedata[2]) begin
            run_reg       <= 1'b1;
            presc_cnt_reg <= writedata[15:8];
          end else if (writedata[3]) begin
            run_reg <= 1'b0;
          end
        end

        if (to_evt_reg)     to_reg <= 1'b1;
        else if (wr_off[0]) to_reg <= 1'b0;
      end
    end

    always_comb begin
      rd_word = '0;
      case (address[2:0])
        3'd0: rd_word = {14'd0, run_reg, to_reg};
        3'd1: rd_word = {presc_reg, 3'd0, pwm_reg, 2'd0, cont_reg, ito_reg};
        3'd2: rd_word = period_ext[15:0];
        3'd3: rd_word = period_ext[31:16];
        3'd4: rd_word = snap_ext[15:0];
        3'd5: rd_word = snap_ext[31:16];
        3'd6: rd_word = cmp_ext[15:0];
        3'd7: rd_word = cmp_ext[31:16];
      endcase
    end

    assign ch_rdata[gi]  = rd_word;
    assign ch_irq[gi]    = to_reg & ito_reg;
    assign timer_out[gi] = pwm_reg ? (run_reg & (cnt_reg < cmp_reg)) : to_evt_reg;
  end

  for (genvar gi = NUM_CH; gi < 4; gi++) begin : g_absent
    assign ch_rdata[gi] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_reg <= '0;
    else       readdata_reg <= ch_rdata[address[4:3]];
  end

  assign readdata = readdata_reg;
  assign irq      = |ch_irq;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed self-checking bench for nios_multi_timer (2 channels, 32-bit counters).
module tb_nios_multi_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [1:0]  timer_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  nios_multi_timer #(.NUM_CH(2), .CNT_W(32), .DEFAULT_PERIOD(49)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .timer_out  (timer_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // All bus tasks are entered right after a falling edge and return after the next one.
  task automatic bus_wr(input logic [4:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("WR addr=%0d data=0x%04h", a, d);
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [15:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
    $display("RD addr=%0d data=0x%04h", a, d);
  endtask

  task automatic wait_tout(input int ch, input int lim, output int n);
    n = 0;
    while (!timer_out[ch] && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_high(input int ch, input int len, output int n);
    n = 0;
    for (int i = 0; i < len; i++) begin
      if (timer_out[ch]) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] rst_exp [8];
    int n;
    rst_exp = '{16'h0000, 16'h0000, 16'h0031, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset values
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tout", 32'(timer_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(5'(i), rd);
      chk($sformatf("rst_ch0_off%0d", i), 32'(rd), 32'(rst_exp[i]));
    end
    bus_rd(5'd18, rd);
    chk("absent_ch2_period", 32'(rd), 32'd0);

    // 2: continuous ch0, period 9
    bus_wr(5'd2, 16'd9);
    bus_wr(5'd3, 16'd0);
    bus_wr(5'd1, 16'h0007);
    wait_tout(0, 100, n);
    chk("first_timeout_cycles", 32'(n), 32'd10);
    chk("irq_before_to", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_with_to", 32'(irq), 32'd1);
    wait_tout(0, 100, n);
    chk("second_timeout_gap", 32'(n), 32'd9);
    @(negedge clk);
    bus_wr(5'd0, 16'd0);
    n = 0;
    while (!irq && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("irq_low_cycles", 32'(n), 32'd9);

    // 5: status write in the event cycle, START|STOP
    wait_tout(0, 100, n);
    chk("third_timeout_gap", 32'(n), 32'd9);
    bus_wr(5'd0, 16'd0);
    bus_rd(5'd0, rd);
    chk("to_survives_clear", 32'(rd), 32'h3);
    bus_wr(5'd1, 16'h0008);
    chk("irq_ito_cleared", 32'(irq), 32'd0);
    bus_rd(5'd0, rd);
    chk("stopped_status", 32'(rd), 32'h1);
    bus_wr(5'd1, 16'h000C);
    bus_rd(5'd0, rd);
    chk("start_stop_status", 32'(rd), 32'h3);
    bus_wr(5'd1, 16'h0008);
    bus_wr(5'd0, 16'd0);

    // 3: ch1 one-shot with prescaler
    bus_wr(5'd10, 16'd3);
    bus_wr(5'd11, 16'd0);
    bus_wr(5'd9, 16'h0405);
    wait_tout(1, 100, n);
    chk("presc_timeout_cycles", 32'(n), 32'd20);
    @(negedge clk);
    bus_rd(5'd8, rd);
    chk("oneshot_status", 32'(rd), 32'h1);
    bus_wr(5'd12, 16'd0);
    bus_rd(5'd12, rd);
    chk("ch1_snap_l", 32'(rd), 32'd3);
    bus_rd(5'd13, rd);
    chk("ch1_snap_h", 32'(rd), 32'd0);
    chk("ch1_irq", 32'(irq), 32'd1);
    bus_wr(5'd8, 16'd0);
    chk("ch1_irq_cleared", 32'(irq), 32'd0);

    // 4: ch0 PWM
    bus_wr(5'd2, 16'd7);
    bus_wr(5'd3, 16'd0);
    bus_wr(5'd6, 16'd3);
    bus_wr(5'd7, 16'd0);
    bus_wr(5'd1, 16'h0016);
    count_high(0, 16, n);
    chk("pwm_cmp3_highs", 32'(n), 32'd6);
    bus_wr(5'd6, 16'd0);
    count_high(0, 16, n);
    chk("pwm_cmp0_highs", 32'(n), 32'd0);
    bus_wr(5'd6, 16'd8);
    count_high(0, 16, n);
    chk("pwm_cmp8_highs", 32'(n), 32'd16);

    // 6: period write while running, then reset mid-count
    bus_wr(5'd2, 16'd5);
    bus_rd(5'd0, rd);
    chk("period_wr_stops", 32'(rd), 32'h1);
    bus_wr(5'd4, 16'd0);
    bus_rd(5'd4, rd);
    chk("period_wr_reload", 32'(rd), 32'd5);
    bus_wr(5'd1, 16'h0007);
    repeat (10) @(negedge clk);
    chk("irq_before_reset", 32'(irq), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_tout", 32'(timer_out), 32'd0);
    chk("reset_readdata", 32'(readdata), 32'd0);
    bus_rd(5'd2, rd);
    chk("reset_period", 32'(rd), 32'h31);
    bus_rd(5'd0, rd);
    chk("reset_status", 32'(rd), 32'd0);
    bus_rd(5'd1, rd);
    chk("reset_control", 32'(rd), 32'd0);
    bus_rd(5'd10, rd);
    chk("reset_ch1_period", 32'(rd), 32'h31);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
